// File: rtl/rv32im_bpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rv32im_bpu_pkg : shared widths, branch opcodes and counter states  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
package rv32im_bpu_pkg;

    localparam int API_ADDR_WIDTH  = 32;
    localparam int API_DATA_WIDTH  = 32;
    localparam int API_BPU_ENTRIES = 16;
    localparam int BR_OPCODE_WIDTH = 3;

    localparam logic [BR_OPCODE_WIDTH-1:0] BR_OPCODE_BEQ = 3'b000;
    localparam logic [BR_OPCODE_WIDTH-1:0] BR_OPCODE_BNE = 3'b001;
    localparam logic [BR_OPCODE_WIDTH-1:0] BR_OPCODE_BLT = 3'b100;
    localparam logic [BR_OPCODE_WIDTH-1:0] BR_OPCODE_BGE = 3'b101;

    localparam logic [1:0] BPU_CTR_SNT = 2'b00;
    localparam logic [1:0] BPU_CTR_WNT = 2'b01;
    localparam logic [1:0] BPU_CTR_WT  = 2'b10;
    localparam logic [1:0] BPU_CTR_ST  = 2'b11;

    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
        if (taken) return (ctr == BPU_CTR_ST)  ? ctr : ctr + 2'd1;
        else       return (ctr == BPU_CTR_SNT) ? ctr : ctr - 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv32im_bpu_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rv32im_bpu_if : fetch prediction, execute resolve and status bus   |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface rv32im_bpu_if
    import rv32im_bpu_pkg::*;
#(
    parameter int ADDR_WIDTH = API_ADDR_WIDTH,
    parameter int CNT_WIDTH  = 32
);
    logic [ADDR_WIDTH-1:0]      if_pc_i;
    logic [ADDR_WIDTH-1:0]      pred_pc_o;
    logic                       pred_taken_o;
    logic                       pred_hit_o;
    logic                       ex_valid_i;
    logic                       br_en_i;
    logic                       br_conditional_i;
    logic [BR_OPCODE_WIDTH-1:0] br_opcode_i;
    logic                       alu_zero_i;
    logic [ADDR_WIDTH-1:0]      curr_pc_i;
    logic [API_DATA_WIDTH-1:0]  imm_i;
    logic [ADDR_WIDTH-1:0]      exu_calc_addr_i;
    logic [ADDR_WIDTH-1:0]      ex_pred_pc_i;
    logic [ADDR_WIDTH-1:0]      nxt_pc_o;
    logic                       redirect_o;
    logic [ADDR_WIDTH-1:0]      redirect_pc_o;
    logic [CNT_WIDTH-1:0]       br_cnt_o;
    logic [CNT_WIDTH-1:0]       mispred_cnt_o;

    modport slave (
        input  if_pc_i, ex_valid_i, br_en_i, br_conditional_i, br_opcode_i,
               alu_zero_i, curr_pc_i, imm_i, exu_calc_addr_i, ex_pred_pc_i,
        output pred_pc_o, pred_taken_o, pred_hit_o, nxt_pc_o, redirect_o,
               redirect_pc_o, br_cnt_o, mispred_cnt_o
    );

    modport master (
        output if_pc_i, ex_valid_i, br_en_i, br_conditional_i, br_opcode_i,
               alu_zero_i, curr_pc_i, imm_i, exu_calc_addr_i, ex_pred_pc_i,
        input  pred_pc_o, pred_taken_o, pred_hit_o, nxt_pc_o, redirect_o,
               redirect_pc_o, br_cnt_o, mispred_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/rv32im_bpu_btb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rv32im_bpu_btb : direct-mapped BTB storage, comb reads, sync write |
// | Counter storage present only with API_BPU_BHT_EN.  Revision 1.0    |
// +--------------------------------------------------------------------+
module rv32im_bpu_btb
    import rv32im_bpu_pkg::*;
#(
    parameter int ENTRIES    = API_BPU_ENTRIES,
    parameter int IDX_W      = 4,
    parameter int TAG_W      = 26,
    parameter int ADDR_WIDTH = API_ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    // Port A serves fetch lookups, port B the resolving instruction
    input  logic [IDX_W-1:0]      rda_idx_i,
    output logic                  rda_valid_o,
    output logic [TAG_W-1:0]      rda_tag_o,
    output logic [ADDR_WIDTH-1:0] rda_target_o,
    input  logic [IDX_W-1:0]      rdb_idx_i,
    output logic                  rdb_valid_o,
    output logic [TAG_W-1:0]      rdb_tag_o,
`ifdef API_BPU_BHT_EN
    output logic [1:0]            rda_ctr_o,
    output logic [1:0]            rdb_ctr_o,
    input  logic [1:0]            wr_ctr_i,
`endif
    input  logic                  wr_en_i,
    input  logic [IDX_W-1:0]      wr_idx_i,
    input  logic                  wr_valid_i,
    input  logic [TAG_W-1:0]      wr_tag_i,
    input  logic [ADDR_WIDTH-1:0] wr_target_i
);
    logic [ENTRIES-1:0]    valid_q;
    logic [TAG_W-1:0]      tag_q    [ENTRIES];
    logic [ADDR_WIDTH-1:0] target_q [ENTRIES];

    always_ff @(posedge clk_i) begin
        if (rst_i)        valid_q           <= '0;
        else if (wr_en_i) valid_q[wr_idx_i] <= wr_valid_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_en_i) begin
            tag_q[wr_idx_i]    <= wr_tag_i;
            target_q[wr_idx_i] <= wr_target_i;
        end
    end

    assign rda_valid_o  = valid_q[rda_idx_i];
    assign rda_tag_o    = tag_q[rda_idx_i];
    assign rda_target_o = target_q[rda_idx_i];
    assign rdb_valid_o  = valid_q[rdb_idx_i];
    assign rdb_tag_o    = tag_q[rdb_idx_i];

`ifdef API_BPU_BHT_EN
    logic [ENTRIES-1:0][1:0] ctr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)        ctr_q           <= {ENTRIES{BPU_CTR_WNT}};
        else if (wr_en_i) ctr_q[wr_idx_i] <= wr_ctr_i;
    end

    assign rda_ctr_o = ctr_q[rda_idx_i];
    assign rdb_ctr_o = ctr_q[rdb_idx_i];
`endif
endmodule
`default_nettype wire

// File: rtl/rv32im_bpu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rv32im_bpu : branch prediction, resolve, redirect and perf counters|
// | Option macro: API_BPU_BHT_EN (2-bit counters).  Revision 1.0       |
// +--------------------------------------------------------------------+
module rv32im_bpu
    import rv32im_bpu_pkg::*;
#(
    parameter int ENTRIES    = API_BPU_ENTRIES,
    parameter int ADDR_WIDTH = API_ADDR_WIDTH,
    parameter int CNT_WIDTH  = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    rv32im_bpu_if.slave bpu
);
    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_WIDTH - IDX - 2;

    logic [IDX-1:0]        w_f_idx, w_e_idx;
    logic [TAG_W-1:0]      w_f_tag, w_e_tag, w_f_rtag, w_e_rtag;
    logic                  w_f_valid, w_e_valid, w_f_hit, w_e_hit, w_f_taken;
    logic [ADDR_WIDTH-1:0] w_f_target, w_br_target, w_seq_pc, w_nxt_pc;
    logic                  w_is_jump, w_is_cond, w_cond_taken, w_taken, w_mispredict;
    logic                  w_wr_en, w_wr_valid;
    logic [ADDR_WIDTH-1:0] w_wr_target;

    assign w_f_idx = bpu.if_pc_i[IDX+1:2];
    assign w_f_tag = bpu.if_pc_i[ADDR_WIDTH-1:IDX+2];
    assign w_e_idx = bpu.curr_pc_i[IDX+1:2];
    assign w_e_tag = bpu.curr_pc_i[ADDR_WIDTH-1:IDX+2];
    assign w_f_hit = w_f_valid && (w_f_rtag == w_f_tag);
    assign w_e_hit = w_e_valid && (w_e_rtag == w_e_tag);

`ifdef API_BPU_BHT_EN
    logic [1:0] w_f_ctr, w_e_ctr, w_wr_ctr;
    assign w_f_taken = w_f_hit && w_f_ctr[1];
`else
    assign w_f_taken = w_f_hit;
`endif

    assign bpu.pred_hit_o   = w_f_hit;
    assign bpu.pred_taken_o = w_f_taken;
    assign bpu.pred_pc_o    = w_f_taken ? w_f_target : bpu.if_pc_i + ADDR_WIDTH'(4);

    always_comb begin
        w_cond_taken = 1'b0;
        case (bpu.br_opcode_i)
            BR_OPCODE_BEQ, BR_OPCODE_BGE: w_cond_taken = bpu.alu_zero_i;
            BR_OPCODE_BNE, BR_OPCODE_BLT: w_cond_taken = ~bpu.alu_zero_i;
            default:                      w_cond_taken = 1'b0;
        endcase
    end

    assign w_is_jump    = bpu.br_en_i && !bpu.br_conditional_i;
    assign w_is_cond    = bpu.br_en_i && bpu.br_conditional_i;
    assign w_taken      = w_is_jump || (w_is_cond && w_cond_taken);
    assign w_br_target  = bpu.curr_pc_i + ADDR_WIDTH'(bpu.imm_i);
    assign w_seq_pc     = bpu.curr_pc_i + ADDR_WIDTH'(4);
    assign w_nxt_pc     = w_is_jump ? bpu.exu_calc_addr_i : (w_taken ? w_br_target : w_seq_pc);
    assign w_mispredict = bpu.ex_valid_i && (w_nxt_pc != bpu.ex_pred_pc_i);
    assign bpu.nxt_pc_o = w_nxt_pc;

    // Conditional entries always store the branch target so a not-taken update keeps it usable
    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_valid  = 1'b1;
        w_wr_target = w_br_target;
`ifdef API_BPU_BHT_EN
        w_wr_ctr    = BPU_CTR_WT;
`endif
        if (bpu.ex_valid_i) begin
            if (w_is_jump) begin
                w_wr_en     = 1'b1;
                w_wr_target = bpu.exu_calc_addr_i;
`ifdef API_BPU_BHT_EN
                w_wr_ctr    = BPU_CTR_ST;
`endif
            end else if (w_is_cond) begin
`ifdef API_BPU_BHT_EN
                if (w_e_hit) begin
                    w_wr_en  = 1'b1;
                    w_wr_ctr = ctr_update(w_e_ctr, w_taken);
                end else if (w_taken) begin
                    w_wr_en  = 1'b1;
                end
`else
                if (w_taken) begin
                    w_wr_en = 1'b1;
                end else if (w_e_hit) begin
                    w_wr_en    = 1'b1;
                    w_wr_valid = 1'b0;
                end
`endif
            end else if (w_e_hit) begin
                w_wr_en    = 1'b1;
                w_wr_valid = 1'b0;
            end
        end
    end

    rv32im_bpu_btb #(
        .ENTRIES    (ENTRIES),
        .IDX_W      (IDX),
        .TAG_W      (TAG_W),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_btb (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rda_idx_i    (w_f_idx),
        .rda_valid_o  (w_f_valid),
        .rda_tag_o    (w_f_rtag),
        .rda_target_o (w_f_target),
        .rdb_idx_i    (w_e_idx),
        .rdb_valid_o  (w_e_valid),
        .rdb_tag_o    (w_e_rtag),
`ifdef API_BPU_BHT_EN
        .rda_ctr_o    (w_f_ctr),
        .rdb_ctr_o    (w_e_ctr),
        .wr_ctr_i     (w_wr_ctr),
`endif
        .wr_en_i      (w_wr_en),
        .wr_idx_i     (w_e_idx),
        .wr_valid_i   (w_wr_valid),
        .wr_tag_i     (w_e_tag),
        .wr_target_i  (w_wr_target)
    );

    logic                  redirect_q;
    logic [ADDR_WIDTH-1:0] redirect_pc_q;
    logic [CNT_WIDTH-1:0]  br_cnt_q, br_cnt_d, mispred_cnt_q, mispred_cnt_d;

    assign br_cnt_d      = (bpu.ex_valid_i && bpu.br_en_i && !(&br_cnt_q))
                         ? br_cnt_q + CNT_WIDTH'(1) : br_cnt_q;
    assign mispred_cnt_d = (w_mispredict && !(&mispred_cnt_q))
                         ? mispred_cnt_q + CNT_WIDTH'(1) : mispred_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            redirect_q    <= w_mispredict;
            if (w_mispredict) redirect_pc_q <= w_nxt_pc;
            br_cnt_q      <= br_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign bpu.redirect_o    = redirect_q;
    assign bpu.redirect_pc_o = redirect_pc_q;
    assign bpu.br_cnt_o      = br_cnt_q;
    assign bpu.mispred_cnt_o = mispred_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_rv32im_bpu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rv32im_bpu : scoreboard bench for rv32im_bpu (either BHT build) |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_rv32im_bpu;
    import rv32im_bpu_pkg::*;

    localparam int AW = 32;
    localparam int CW = 4;
    localparam int N  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rv32im_bpu_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

    rv32im_bpu #(.ENTRIES(N), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bpu   (bus)
    );

    typedef struct packed {
        logic          redir;
        logic [AW-1:0] pc;
    } exp_t;

    exp_t          sb[$];
    logic          m_valid [N];
    logic [AW-7:0] m_tag   [N];
    logic [AW-1:0] m_tgt   [N];
    logic [1:0]    m_ctr   [N];
    logic [CW-1:0] m_br, m_mis;
    logic [AW-1:0] m_rpc;
    int errors = 0;
    int checks = 0;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 2'b01;
        end
        m_br  = '0;
        m_mis = '0;
        m_rpc = '0;
        sb.delete();
    endtask

    task automatic check_pred(input string name);
        logic [3:0]    i;
        logic          hit, tk;
        logic [AW-1:0] epc;
        i   = bus.if_pc_i[5:2];
        hit = m_valid[i] && (m_tag[i] == bus.if_pc_i[AW-1:6]);
`ifdef API_BPU_BHT_EN
        tk  = hit && m_ctr[i][1];
`else
        tk  = hit;
`endif
        epc = tk ? m_tgt[i] : bus.if_pc_i + 32'd4;
        checks++;
        if (bus.pred_hit_o !== hit) begin
            errors++;
            $display("FAIL %s pred_hit: got %b expected %b", name, bus.pred_hit_o, hit);
        end
        checks++;
        if (bus.pred_taken_o !== tk) begin
            errors++;
            $display("FAIL %s pred_taken: got %b expected %b", name, bus.pred_taken_o, tk);
        end
        checks++;
        if (bus.pred_pc_o !== epc) begin
            errors++;
            $display("FAIL %s pred_pc: got %h expected %h", name, bus.pred_pc_o, epc);
        end
    endtask

    task automatic lookup(input logic [AW-1:0] pc, input string name);
        bus.if_pc_i = pc;
        #1;
        check_pred(name);
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: got empty queue expected an entry", name);
        end else begin
            e = sb.pop_front();
            if (bus.redirect_o !== e.redir) begin
                errors++;
                $display("FAIL %s redirect: got %b expected %b", name, bus.redirect_o, e.redir);
            end
            checks++;
            if (bus.redirect_pc_o !== e.pc) begin
                errors++;
                $display("FAIL %s redirect_pc: got %h expected %h", name, bus.redirect_pc_o, e.pc);
            end
        end
        checks++;
        if (bus.br_cnt_o !== m_br) begin
            errors++;
            $display("FAIL %s br_cnt: got %0d expected %0d", name, bus.br_cnt_o, m_br);
        end
        checks++;
        if (bus.mispred_cnt_o !== m_mis) begin
            errors++;
            $display("FAIL %s mispred_cnt: got %0d expected %0d", name, bus.mispred_cnt_o, m_mis);
        end
    endtask

    task automatic idle(input string name);
        bus.ex_valid_i = 1'b0;
        sb.push_back('{redir: 1'b0, pc: m_rpc});
        @(posedge clk);
        #1;
        pop_check(name);
    endtask

    task automatic resolve(input logic en, input logic cond, input logic [2:0] op,
                           input logic zero, input logic [AW-1:0] pc, input logic [AW-1:0] imm,
                           input logic [AW-1:0] calc, input logic [AW-1:0] pred,
                           input string name);
        logic          jump, ctk, tk, hit, mis;
        logic [AW-1:0] nxt, btgt;
        logic [3:0]    i;
        bus.ex_valid_i       = 1'b1;
        bus.br_en_i          = en;
        bus.br_conditional_i = cond;
        bus.br_opcode_i      = op;
        bus.alu_zero_i       = zero;
        bus.curr_pc_i        = pc;
        bus.imm_i            = imm;
        bus.exu_calc_addr_i  = calc;
        bus.ex_pred_pc_i     = pred;
        #1;
        jump = en && !cond;
        case (op)
            3'b000, 3'b101: ctk = zero;
            3'b001, 3'b100: ctk = !zero;
            default:        ctk = 1'b0;
        endcase
        tk   = jump || (en && cond && ctk);
        btgt = pc + imm;
        nxt  = jump ? calc : (tk ? btgt : pc + 32'd4);
        checks++;
        if (bus.nxt_pc_o !== nxt) begin
            errors++;
            $display("FAIL %s nxt_pc: got %h expected %h", name, bus.nxt_pc_o, nxt);
        end
        check_pred({name, "/same_cycle_lookup"});
        mis = (nxt != pred);
        if (mis) m_rpc = nxt;
        sb.push_back('{redir: mis, pc: m_rpc});
        if (en && m_br != '1) m_br = m_br + 1'b1;
        if (mis && m_mis != '1) m_mis = m_mis + 1'b1;
        i   = pc[5:2];
        hit = m_valid[i] && (m_tag[i] == pc[AW-1:6]);
        if (jump) begin
            m_valid[i] = 1'b1; m_tag[i] = pc[AW-1:6]; m_tgt[i] = calc; m_ctr[i] = 2'b11;
        end else if (en) begin
`ifdef API_BPU_BHT_EN
            if (hit) begin
                m_tgt[i] = btgt;
                if (tk && m_ctr[i] != 2'b11) m_ctr[i] = m_ctr[i] + 2'd1;
                if (!tk && m_ctr[i] != 2'b00) m_ctr[i] = m_ctr[i] - 2'd1;
            end else if (tk) begin
                m_valid[i] = 1'b1; m_tag[i] = pc[AW-1:6]; m_tgt[i] = btgt; m_ctr[i] = 2'b10;
            end
`else
            if (tk) begin
                m_valid[i] = 1'b1; m_tag[i] = pc[AW-1:6]; m_tgt[i] = btgt;
            end else if (hit) begin
                m_valid[i] = 1'b0;
            end
`endif
        end else if (hit) begin
            m_valid[i] = 1'b0;
        end
        @(posedge clk);
        #1;
        pop_check(name);
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus.ex_valid_i = 1'b0;
        bus.if_pc_i    = 32'h100;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        sb.push_back('{redir: 1'b0, pc: 32'h0});
        pop_check("reset");
        lookup(32'h100, "reset_lookup");
    endtask

    task automatic test_taken_branch();
        bus.if_pc_i = 32'h300;
        resolve(1, 1, BR_OPCODE_BEQ, 1, 32'h100, 32'h40, 32'h0, 32'h104, "beq_taken");
        checks++;
        if (bus.redirect_pc_o !== 32'h140) begin
            errors++;
            $display("FAIL beq_taken redirect_target: got %h expected %h", bus.redirect_pc_o, 32'h140);
        end
        idle("beq_redirect_drop");
        lookup(32'h100, "beq_lookup");
    endtask

    task automatic test_not_taken();
        resolve(1, 1, BR_OPCODE_BNE, 1, 32'h100, 32'h40, 32'h0, 32'h140, "bne_nt1");
        idle("bne_nt1_idle");
        lookup(32'h100, "bne_nt1_lookup");
        resolve(1, 1, BR_OPCODE_BNE, 1, 32'h100, 32'h40, 32'h0, 32'h104, "bne_nt2");
        idle("bne_nt2_idle");
        lookup(32'h100, "bne_nt2_lookup");
    endtask

    task automatic test_jump();
        resolve(1, 0, 3'b000, 0, 32'h200, 32'h0, 32'h800, 32'h800, "jump_predicted");
        idle("jump_idle");
        lookup(32'h200, "jump_lookup");
    endtask

    task automatic test_same_index();
        resolve(1, 0, 3'b000, 0, 32'h140, 32'h0, 32'h900, 32'h144, "alias_jump");
        idle("alias_jump_idle");
        bus.if_pc_i = 32'h140;
        resolve(1, 1, BR_OPCODE_BEQ, 1, 32'h100, 32'h40, 32'h0, 32'h104, "same_idx_update");
        idle("same_idx_idle");
        lookup(32'h140, "same_idx_old_miss");
        lookup(32'h100, "same_idx_new_hit");
    endtask

    task automatic test_alias_clear();
        bus.if_pc_i = 32'h200;
        resolve(0, 0, 3'b000, 0, 32'h200, 32'h0, 32'h0, 32'h204, "non_branch_clear");
        resolve(1, 1, 3'b010, 1, 32'h300, 32'h10, 32'h0, 32'h304, "bad_opcode");
        idle("alias_idle");
        lookup(32'h200, "alias_cleared");
        lookup(32'h300, "bad_opcode_nowrite");
    endtask

    task automatic test_back_to_back();
        resolve(1, 0, 3'b000, 0, 32'h400, 32'h0, 32'hA00, 32'h404, "b2b_first");
        resolve(1, 1, BR_OPCODE_BEQ, 1, 32'h500, 32'h20, 32'h0, 32'h504, "b2b_second");
        idle("b2b_idle");
        lookup(32'h400, "b2b_lookup_jump");
        lookup(32'h500, "b2b_lookup_beq");
    endtask

    task automatic test_wrap();
        resolve(1, 1, BR_OPCODE_BGE, 0, 32'hFFFF_FFFC, 32'h40, 32'h0, 32'h0, "wrap_seq");
        resolve(1, 1, BR_OPCODE_BLT, 0, 32'hFFFF_FFF0, 32'h20, 32'h0, 32'h10, "wrap_target");
        idle("wrap_idle");
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 20; k++)
            resolve(1, 0, 3'b000, 0, 32'h600, 32'h0, 32'hC00 + 32'(k * 4), 32'h0, "saturate");
        idle("saturate_idle");
        checks++;
        if (bus.mispred_cnt_o !== {CW{1'b1}}) begin
            errors++;
            $display("FAIL saturate_all_ones: got %h expected %h", bus.mispred_cnt_o, {CW{1'b1}});
        end
    endtask

    task automatic test_reset_mid();
        resolve(1, 0, 3'b000, 0, 32'h700, 32'h0, 32'hD00, 32'h0, "pre_reset_mispredict");
        // reset lands in the redirect cycle while a jump write is also presented
        rst                 = 1'b1;
        bus.ex_valid_i      = 1'b1;
        bus.curr_pc_i       = 32'h740;
        bus.exu_calc_addr_i = 32'hE00;
        bus.ex_pred_pc_i    = 32'h0;
        @(posedge clk);
        #1;
        rst            = 1'b0;
        bus.ex_valid_i = 1'b0;
        model_reset();
        sb.push_back('{redir: 1'b0, pc: 32'h0});
        pop_check("reset_mid");
        lookup(32'h740, "reset_mid_write_dropped");
        lookup(32'h700, "reset_mid_table_cleared");
    endtask

    initial begin
        bus.if_pc_i          = '0;
        bus.ex_valid_i       = 1'b0;
        bus.br_en_i          = 1'b0;
        bus.br_conditional_i = 1'b0;
        bus.br_opcode_i      = '0;
        bus.alu_zero_i       = 1'b0;
        bus.curr_pc_i        = '0;
        bus.imm_i            = '0;
        bus.exu_calc_addr_i  = '0;
        bus.ex_pred_pc_i     = '0;
        model_reset();
        test_reset();
        test_taken_branch();
        test_not_taken();
        test_jump();
        test_same_index();
        test_alias_clear();
        test_back_to_back();
        test_wrap();
        test_saturation();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
